// File: rtl/crc_stream_codec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : crc_stream_codec
// Purpose  : Bit-serial CRC encoder/checker for a byte stream with
//            valid/ready handshakes. Encode mode returns the remainder of the
//            message. Check mode returns the syndrome over message plus the
//            appended CRC and flags a non-zero syndrome.
// Revision : 1.0 - initial release
// ============================================================================
module crc_stream_codec #(
  parameter int                 MSG_BYTES = 2,
  parameter int                 CRC_W     = 8,
  parameter logic [CRC_W-1:0]   POLY      = 8'h07
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_byte_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CRC_W-1:0] crc_out_o,
  output logic             crc_err_o,
  output logic             busy_o
);

  localparam int CRC_BYTES = (CRC_W + 7) / 8;
  localparam int LAST_BITS = CRC_W - 8 * (CRC_BYTES - 1);
  localparam int FRAME_MAX = MSG_BYTES + CRC_BYTES;
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);

  localparam logic [CNT_W-1:0] MSG_CNT   = CNT_W'(MSG_BYTES);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_MAX);
  localparam logic [2:0]       SEG_FULL  = 3'd7;
  localparam logic [2:0]       SEG_LAST  = 3'(LAST_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [CRC_W-1:0]   crc_q,      crc_d;
  logic [7:0]         shreg_q,    shreg_d;
  logic               mode_q,     mode_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]         bit_cnt_q,  bit_cnt_d;
  logic [CRC_W-1:0]   crc_out_q,  crc_out_d;
  logic               crc_err_q,  crc_err_d;

  logic               w_fb;
  logic [CRC_W-1:0]   w_crc_step;
  logic               w_last_byte;
  logic [2:0]         w_seg_end;

  // One MSB-first CRC step using the current top bit of the latched byte.
  always_comb begin
    w_fb       = crc_q[CRC_W-1] ^ shreg_q[7];
    w_crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end

  // Frame position: the final byte of a check frame carries only LAST_BITS.
  always_comb begin
    w_last_byte = (byte_cnt_q == (mode_q ? FRAME_CNT : MSG_CNT));
    w_seg_end   = (mode_q && w_last_byte) ? SEG_LAST : SEG_FULL;
  end

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    crc_out_d  = crc_out_q;
    crc_err_d  = crc_err_q;
    case (state_q)
      S_IDLE: begin
        crc_d     = '0;
        bit_cnt_d = '0;
        if (in_valid_i) begin
          shreg_d    = in_byte_i;
          mode_d     = mode_i;
          byte_cnt_d = CNT_W'(1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        crc_d     = w_crc_step;
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == w_seg_end) begin
          bit_cnt_d = '0;
          if (w_last_byte) begin
            crc_out_d = w_crc_step;
            crc_err_d = mode_q & (|w_crc_step);
            state_d   = S_DONE;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (in_valid_i) begin
          shreg_d    = in_byte_i;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      crc_q      <= '0;
      shreg_q    <= '0;
      mode_q     <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      crc_out_q  <= '0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      shreg_q    <= shreg_d;
      mode_q     <= mode_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_out_q  <= crc_out_d;
      crc_err_q  <= crc_err_d;
    end
  end

  // Handshake and status outputs decode the registered state only.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE) || (state_q == S_WAIT);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE);
    crc_out_o   = crc_out_q;
    crc_err_o   = crc_err_q;
  end

endmodule
`default_nettype wire
